// File: rtl/gnpu_pkg.sv
// -----------------------------------------------------------------------------
// gnpu_pkg
// Shared types and sizing constants for the GNPU operand feeders.
//   feed_state_e       : feeder FSM states (IDLE, ISSUE, DRAIN, FINISH)
//   TMMA_CNT_W         : row address / row count width (from `TMMA_CNT_WIDTH)
//   SARRAY_LOAD_W      : width of one operand row (from `SARRAY_LOAD_WIDTH)
//   A_FEED_FIFO_DEPTH  : default return-data FIFO depth of the A feeder
// The width macros fall back to local defaults when the build does not set them.
// -----------------------------------------------------------------------------
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 16
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif

package gnpu_pkg;

    localparam int TMMA_CNT_W        = `TMMA_CNT_WIDTH;
    localparam int SARRAY_LOAD_W     = `SARRAY_LOAD_WIDTH;
    localparam int A_FEED_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feed_state_e;

endpackage

// File: rtl/a_buf_feeder_if.sv
// -----------------------------------------------------------------------------
// a_buf_feeder_if
// Bus bundle between the A feeder, the A operand buffer read port and the
// systolic-array A input. Signal suffixes are from the feeder's point of view.
//   rd_a_buf_valid_o/id_o/addr_o       : row read request to the A buffer
//   rd_a_buf_ret_valid_i/ret_data_i    : in-order read return (no backpressure)
//   sarray_a_valid_o/data_o/ready_i    : row stream to the systolic array
// Modports: master = feeder side, slave = buffer/array side.
// -----------------------------------------------------------------------------
interface a_buf_feeder_if
    import gnpu_pkg::*;
#(
    parameter int CNT_W = TMMA_CNT_W,
    parameter int DW    = SARRAY_LOAD_W
) ();

    logic             rd_a_buf_valid_o;
    logic             rd_a_buf_id_o;
    logic [CNT_W-1:0] rd_a_buf_addr_o;
    logic             rd_a_buf_ret_valid_i;
    logic [DW-1:0]    rd_a_buf_ret_data_i;
    logic             sarray_a_valid_o;
    logic [DW-1:0]    sarray_a_data_o;
    logic             sarray_a_ready_i;

    modport master (
        output rd_a_buf_valid_o, rd_a_buf_id_o, rd_a_buf_addr_o,
        input  rd_a_buf_ret_valid_i, rd_a_buf_ret_data_i,
        output sarray_a_valid_o, sarray_a_data_o,
        input  sarray_a_ready_i
    );

    modport slave (
        input  rd_a_buf_valid_o, rd_a_buf_id_o, rd_a_buf_addr_o,
        output rd_a_buf_ret_valid_i, rd_a_buf_ret_data_i,
        input  sarray_a_valid_o, sarray_a_data_o,
        output sarray_a_ready_i
    );

endinterface

// File: rtl/gnpu_sync_fifo.sv
// -----------------------------------------------------------------------------
// gnpu_sync_fifo
// Single-clock FIFO shared by the A and B operand feeders. No bypass: a push
// into an empty FIFO becomes visible on the head the following cycle.
// Push and pop in the same cycle are both honoured (also when full).
//   clk, rst         : clock, synchronous active-high reset
//   push_i, push_data_i
//   pop_i, pop_data_o: pop_data_o is the current head (valid when !empty_o)
//   count_o          : occupancy, 0..DEPTH
//   full_o, empty_o
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module gnpu_sync_fifo
    import gnpu_pkg::*;
#(
    parameter int DW    = SARRAY_LOAD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/a_buf_feeder.sv
// -----------------------------------------------------------------------------
// a_buf_feeder
// Read-side initiator for the double-buffered A operand buffer. On start it
// reads len rows of the chosen bank (one request per cycle while credit
// allows), buffers the in-order returns in a small FIFO and streams them to
// the systolic-array A input. When the pass ends it pulses done_o and
// buf_release_o so the A loader can refill the bank.
//   clk, rst                 : clock, synchronous active-high reset
//   start_i, start_id_i      : start a pass on a bank (accepted only when idle)
//   len_i                    : rows to feed; 0 completes with no reads
//   busy_o, done_o           : status; done_o is a one-cycle pulse
//   buf_release_o/_id_o      : one-cycle pulse naming the freed bank
//   err_o                    : sticky, a return arrived with nothing outstanding
//   bus (master)             : read request/return and array stream
// Optional: `A_BUF_FEEDER_PERF_EN adds saturating stall_cnt_o / starve_cnt_o.
// -----------------------------------------------------------------------------
module a_buf_feeder
    import gnpu_pkg::*;
#(
    parameter int CNT_W      = TMMA_CNT_W,
    parameter int DW         = SARRAY_LOAD_W,
    parameter int FIFO_DEPTH = A_FEED_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             start_id_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             buf_release_o,
    output logic             buf_release_id_o,
    output logic             err_o,
    a_buf_feeder_if.master   bus
`ifdef A_BUF_FEEDER_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      starve_cnt_o
`endif
);

    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    feed_state_e      state_q, state_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] addr_q, addr_d;
    logic [OW-1:0]    out_q, out_d;
    logic             err_q, err_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [OW-1:0]    fifo_count;
    logic [DW-1:0]    fifo_head;
    logic [OW:0]      in_flight;
    logic             issue, ret_ok;

    // Every row that is requested or already buffered holds one FIFO slot,
    // so a return always has room when it lands.
    assign in_flight = {1'b0, out_q} + {1'b0, fifo_count};
    assign issue     = (state_q == ISSUE) && (in_flight < (OW+1)'(FIFO_DEPTH));

    // Returns with nothing outstanding are dropped (stale after reset, or bogus).
    assign ret_ok    = bus.rd_a_buf_ret_valid_i && (out_q != '0);
    assign fifo_push = ret_ok;
    assign fifo_pop  = !fifo_empty && bus.sarray_a_ready_i;

    gnpu_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (bus.rd_a_buf_ret_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        addr_d  = addr_q;
        out_d   = out_q;
        err_d   = err_q;

        // Unexpected returns only count as errors while a pass is active.
        if (bus.rd_a_buf_ret_valid_i && (out_q == '0) && (state_q != IDLE))
            err_d = 1'b1;

        case ({issue, ret_ok})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    id_d    = start_id_i;
                    len_d   = len_i;
                    addr_d  = '0;
                    state_d = (len_i == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + CNT_W'(1);
                    if (addr_q == len_q - CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing in flight and nothing buffered: last row has left.
                if ((out_q == '0) && fifo_empty) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == FINISH);
    assign buf_release_o    = (state_q == FINISH);
    assign buf_release_id_o = (state_q == FINISH) && id_q;
    assign err_o            = err_q;

    assign bus.rd_a_buf_valid_o = issue;
    assign bus.rd_a_buf_id_o    = id_q;
    assign bus.rd_a_buf_addr_o  = addr_q;
    assign bus.sarray_a_valid_o = !fifo_empty;
    // Head storage is not reset; present zero while there is no row.
    assign bus.sarray_a_data_o  = fifo_empty ? '0 : fifo_head;

`ifdef A_BUF_FEEDER_PERF_EN
    logic [31:0] stall_q, starve_q;

    always_ff @(posedge clk) begin
        if (rst || ((state_q == IDLE) && start_i)) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            if (!fifo_empty && !bus.sarray_a_ready_i && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (((state_q == ISSUE) || (state_q == DRAIN)) && fifo_empty && (starve_q != '1))
                starve_q <= starve_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign starve_cnt_o = starve_q;
`endif

    // The credit rule must never let a return land on a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_a_buf_feeder.sv
// -----------------------------------------------------------------------------
// tb_a_buf_feeder
// Directed bench for a_buf_feeder. A responder models the A buffer with a
// configurable in-order return latency; a monitor records requests, delivered
// rows and done/release pulses. Expected rows are the bench's own encoding of
// (bank, address).
// -----------------------------------------------------------------------------
module tb_a_buf_feeder;

    localparam int CW = 16;
    localparam int DW = 64;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          start_id;
    logic [CW-1:0] len;
    logic          busy, done, rel, rel_id, err;
`ifdef A_BUF_FEEDER_PERF_EN
    logic [31:0]   stall_cnt, starve_cnt;
`endif

    a_buf_feeder_if #(.CNT_W(CW), .DW(DW)) bus ();

    a_buf_feeder #(.CNT_W(CW), .DW(DW), .FIFO_DEPTH(FD)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .start_id_i       (start_id),
        .len_i            (len),
        .busy_o           (busy),
        .done_o           (done),
        .buf_release_o    (rel),
        .buf_release_id_o (rel_id),
        .err_o            (err),
        .bus              (bus)
`ifdef A_BUF_FEEDER_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .starve_cnt_o     (starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] mk(input logic id, input logic [15:0] a);
        return {16'hDA7A, 15'd0, id, 16'h0000, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int            mcyc = 0;
    int            done_cnt = 0;
    int            rel_cnt = 0;
    logic          rel_id_seen = 1'b0;
    logic [CW-1:0] req_addr[$];
    logic          req_id[$];
    int            req_cyc[$];
    logic [63:0]   row[$];
    int            row_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (bus.rd_a_buf_valid_o) begin
                req_addr.push_back(bus.rd_a_buf_addr_o);
                req_id.push_back(bus.rd_a_buf_id_o);
                req_cyc.push_back(mcyc);
            end
            if (bus.sarray_a_valid_o && bus.sarray_a_ready_i) begin
                row.push_back(bus.sarray_a_data_o);
                row_cyc.push_back(mcyc);
            end
            if (done) done_cnt++;
            if (rel) begin
                rel_cnt++;
                rel_id_seen = rel_id;
            end
        end
    end

    task automatic clear_mon();
        req_addr.delete(); req_id.delete(); req_cyc.delete();
        row.delete(); row_cyc.delete();
        done_cnt = 0; rel_cnt = 0; rel_id_seen = 1'b0;
    endtask

    // ---------------- A buffer responder ----------------
    int          lat = 1;
    logic        inj = 1'b0;
    int          rcyc = 0;
    int          due_q[$];
    logic [63:0] dat_q[$];

    initial begin
        bus.rd_a_buf_ret_valid_i = 1'b0;
        bus.rd_a_buf_ret_data_i  = '0;
        forever begin
            @(posedge clk);
            #2;
            rcyc++;
            if (due_q.size() > 0 && due_q[0] <= rcyc) begin
                bus.rd_a_buf_ret_valid_i = 1'b1;
                bus.rd_a_buf_ret_data_i  = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                bus.rd_a_buf_ret_valid_i = inj;
                bus.rd_a_buf_ret_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            @(negedge clk);
            if (bus.rd_a_buf_valid_o) begin
                due_q.push_back(rcyc + lat);
                dat_q.push_back(mk(bus.rd_a_buf_id_o, bus.rd_a_buf_addr_o));
            end
        end
    end

    task automatic wait_done(input string tag, input int max);
        bit seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_rows(input string tag, input logic id, input int n);
        chk({tag, "_nrows"}, 64'(row.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_row%0d", tag, i), (i < row.size()) ? row[i] : 64'hx, mk(id, 16'(i)));
    endtask

    task automatic chk_reqs(input string tag, input logic id, input int n);
        chk({tag, "_nreq"}, 64'(req_addr.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), (i < req_addr.size()) ? 64'(req_addr[i]) : 64'hx, 64'(i));
            chk($sformatf("%s_id%0d", tag, i), (i < req_id.size()) ? 64'(req_id[i]) : 64'hx, 64'(id));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_id = 1'b0; len = '0;
        bus.sarray_a_ready_i = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_status", {busy, done, rel, rel_id, err}, 64'd0);
        chk("reset_bus", {bus.rd_a_buf_valid_o, bus.sarray_a_valid_o}, 64'd0);
        chk("reset_data", bus.sarray_a_data_o, 64'd0);
        step(); rst = 1'b0;
        step();

        // T1: len=4 on bank 1, full throughput
        clear_mon(); start = 1'b1; start_id = 1'b1; len = 16'd4;
        step(); start = 1'b0;
        wait_done("t1", 40);
        step(); step();
        chk_reqs("t1", 1'b1, 4);
        chk("t1_req_consec", 64'(req_cyc.size() == 4 ? req_cyc[3] - req_cyc[0] : -1), 64'd3);
        chk_rows("t1", 1'b1, 4);
        chk("t1_row_consec", 64'(row_cyc.size() == 4 ? row_cyc[3] - row_cyc[0] : -1), 64'd3);
        chk("t1_startup", 64'(row_cyc.size() > 0 && req_cyc.size() > 0 ? row_cyc[0] - req_cyc[0] : -1), 64'd2);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_rel_cnt", 64'(rel_cnt), 64'd1);
        chk("t1_rel_id", 64'(rel_id_seen), 64'd1);

        // T2: len=8 with the array stalled, issue must stop at FIFO depth
        clear_mon(); start = 1'b1; start_id = 1'b0; len = 16'd8;
        bus.sarray_a_ready_i = 1'b0;
        step(); start = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t2_issued_stalled", 64'(req_addr.size()), 64'(FD));
        chk("t2_issue_blocked", 64'(bus.rd_a_buf_valid_o), 64'd0);
        chk("t2_head_valid", 64'(bus.sarray_a_valid_o), 64'd1);
        chk("t2_head_data", bus.sarray_a_data_o, mk(1'b0, 16'd0));
        step(); bus.sarray_a_ready_i = 1'b1;
        wait_done("t2", 60);
        step(); step();
        chk_reqs("t2", 1'b0, 8);
        chk_rows("t2", 1'b0, 8);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);

        // T3: len=0 completes with no reads
        clear_mon(); start = 1'b1; start_id = 1'b1; len = 16'd0;
        step(); start = 1'b0;
        @(negedge clk);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_release", {rel, rel_id}, 64'd3);
        @(negedge clk);
        chk("t3_idle", {busy, done, rel}, 64'd0);
        step(); step();
        chk("t3_no_reads", 64'(req_addr.size()), 64'd0);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);

        // T4: second start while busy is ignored
        clear_mon(); start = 1'b1; start_id = 1'b1; len = 16'd3;
        step(); start = 1'b0;
        step(); step();
        start = 1'b1; start_id = 1'b0; len = 16'd5;
        step(); start = 1'b0;
        wait_done("t4", 40);
        repeat (5) step();
        chk_reqs("t4", 1'b1, 3);
        chk_rows("t4", 1'b1, 3);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);
        chk("t4_rel_id", 64'(rel_id_seen), 64'd1);

        // T5: spurious return in the first ISSUE cycle (nothing outstanding)
        clear_mon(); start = 1'b1; start_id = 1'b0; len = 16'd2;
        step(); start = 1'b0; inj = 1'b1;
        step(); inj = 1'b0;
        @(negedge clk);
        chk("t5_err_set", 64'(err), 64'd1);
        chk("t5_fifo_unchanged", 64'(bus.sarray_a_valid_o), 64'd0);
        wait_done("t5", 40);
        step();
        chk_rows("t5", 1'b0, 2);
        chk("t5_err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t5_err_cleared", 64'(err), 64'd0);

        // T6: reset with two reads outstanding, late returns dropped in IDLE
        step();
        clear_mon(); lat = 4; start = 1'b1; start_id = 1'b1; len = 16'd2;
        step(); start = 1'b0;
        step(); step();
        chk("t6_two_reqs", 64'(req_addr.size()), 64'd2);
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_status", {busy, done, rel, rel_id, err}, 64'd0);
        chk("t6_rst_bus", {bus.rd_a_buf_valid_o, bus.sarray_a_valid_o}, 64'd0);
        step(); clear_mon();
        repeat (8) step();
        @(negedge clk);
        chk("t6_late_err", 64'(err), 64'd0);
        chk("t6_late_idle", {busy, bus.sarray_a_valid_o}, 64'd0);
        chk("t6_late_rows", 64'(row.size()), 64'd0);
        step();
        clear_mon(); lat = 1; start = 1'b1; start_id = 1'b0; len = 16'd2;
        step(); start = 1'b0;
        wait_done("t6", 40);
        step(); step();
        chk_reqs("t6", 1'b0, 2);
        chk_rows("t6", 1'b0, 2);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_err_final", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
